// File: rtl/led_pkg.sv
// LED sequencer shared types: pattern modes and bounce direction.
// Latency: n/a (types only).
// Backpressure: n/a.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } led_dir_t;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a 1-cycle tick every TICK_DIV enabled clk cycles.
// Latency: first tick exactly TICK_DIV cycles after en rises.
// Backpressure: none; en=0 clears the count and suppresses the tick.
module led_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick_q;

  // Count enabled cycles; register the tick so it lands on the cycle after the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      tick_q <= 1'b0;
    end
  end

  // Dropping en during a pending tick cancels that step.
  assign tick = tick_q & en;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer (chase/bounce/blink/off) stepped by an internal prescaler.
// Latency: led updates at the clk edge closing the step_tick cycle.
// Backpressure: none; en=0 freezes prescaler and pattern, mode sampled on step only.
module led_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 3,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick
);

  localparam int POS_W = $clog2(NUM_LEDS + 1);
  localparam logic [POS_W-1:0]    POS_END  = POS_W'(NUM_LEDS);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LED_ALL  = {NUM_LEDS{1'b1}};

  led_mode_t           mode_sel;
  led_mode_t           cur_mode, cur_mode_nxt;
  logic [POS_W-1:0]    pos, pos_nxt;
  led_dir_t            dir, dir_nxt;
  logic                phase, phase_nxt;
  logic [NUM_LEDS-1:0] led_nxt;

  assign mode_sel = led_mode_t'(mode);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (step_tick)
  );

  // Pattern state and LED drive register; only the next-state logic moves them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode <= MODE_OFF;
      pos      <= '0;
      dir      <= DIR_UP;
      phase    <= 1'b0;
      led      <= '0;
    end else begin
      cur_mode <= cur_mode_nxt;
      pos      <= pos_nxt;
      dir      <= dir_nxt;
      phase    <= phase_nxt;
      led      <= led_nxt;
    end
  end

  // Next-state/LED decode: hold everything unless a step is taken.
  always_comb begin
    cur_mode_nxt = cur_mode;
    pos_nxt      = pos;
    dir_nxt      = dir;
    phase_nxt    = phase;
    led_nxt      = led;
    if (step_tick) begin
      if (mode_sel != cur_mode) begin
        // New pattern restarts from its first frame.
        cur_mode_nxt = mode_sel;
        pos_nxt      = '0;
        dir_nxt      = DIR_UP;
        phase_nxt    = 1'b1;
        case (mode_sel)
          MODE_CHASE, MODE_BOUNCE: led_nxt = LED_ONE;
          MODE_BLINK:              led_nxt = LED_ALL;
          default:                 led_nxt = '0;
        endcase
      end else begin
        // Out-of-range position recovers to 0 in every mode.
        if (pos > POS_END) pos_nxt = '0;
        case (cur_mode)
          MODE_CHASE: begin
            // pos == NUM_LEDS is the dark gap frame before wrapping.
            if (pos >= POS_END) begin
              pos_nxt = '0;
              led_nxt = LED_ONE;
            end else if (pos == POS_LAST) begin
              pos_nxt = POS_END;
              led_nxt = '0;
            end else begin
              pos_nxt = pos + 1'b1;
              led_nxt = LED_ONE << pos_nxt;
            end
          end
          MODE_BOUNCE: begin
            if (pos >= POS_END || NUM_LEDS == 1) begin
              pos_nxt = '0;
              dir_nxt = DIR_UP;
              led_nxt = LED_ONE;
            end else begin
              // Turn around at the ends so end LEDs are lit for one step only.
              if (dir == DIR_UP) begin
                if (pos == POS_LAST) begin
                  pos_nxt = pos - 1'b1;
                  dir_nxt = DIR_DOWN;
                end else begin
                  pos_nxt = pos + 1'b1;
                end
              end else begin
                if (pos == '0) begin
                  pos_nxt = POS_W'(1);
                  dir_nxt = DIR_UP;
                end else begin
                  pos_nxt = pos - 1'b1;
                end
              end
              led_nxt = LED_ONE << pos_nxt;
            end
          end
          MODE_BLINK: begin
            phase_nxt = ~phase;
            led_nxt   = phase ? '0 : LED_ALL;
          end
          default: begin
            led_nxt = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer across four parameter sets.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_sequencer;
  import led_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst  [4];
  logic       en   [4];
  logic [1:0] mode [4];
  logic       tick [4];
  logic [2:0] led0;
  logic [3:0] led1;
  logic [2:0] led2;
  logic [0:0] led3;

  int checks = 0;
  int errors = 0;

  led_sequencer #(.NUM_LEDS(3), .TICK_DIV(4)) u_dut (
    .clk(clk), .rst(rst[0]), .en(en[0]), .mode(mode[0]), .led(led0), .step_tick(tick[0]));
  led_sequencer #(.NUM_LEDS(4), .TICK_DIV(4)) u_b4 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .mode(mode[1]), .led(led1), .step_tick(tick[1]));
  led_sequencer #(.NUM_LEDS(3), .TICK_DIV(1)) u_t1 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .mode(mode[2]), .led(led2), .step_tick(tick[2]));
  led_sequencer #(.NUM_LEDS(1), .TICK_DIV(4)) u_n1 (
    .clk(clk), .rst(rst[3]), .en(en[3]), .mode(mode[3]), .led(led3), .step_tick(tick[3]));

  // Wait (bounded) at negedges for a step pulse; t = cycle stamp or -1 on timeout.
  task automatic wait_tick(input int which, output int t);
    int n;
    n = 0;
    t = -1;
    while (t < 0 && n < 64) begin
      if (tick[which]) t = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  // Pulse reset on one instance; returns at a negedge with rst low and en low.
  task automatic do_reset(input int which);
    @(negedge clk);
    rst[which]  = 1'b1;
    en[which]   = 1'b0;
    mode[which] = MODE_OFF;
    repeat (2) @(negedge clk);
    rst[which] = 1'b0;
  endtask

  task automatic test_reset;
    int c0, t;
    repeat (2) @(negedge clk);
    checks++; if (led0 !== 3'b000) begin errors++; $display("FAIL reset_led got %b want 000", led0); end
    checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick[0]); end
    rst[0] = 1'b0; en[0] = 1'b1; mode[0] = MODE_CHASE; c0 = cyc;
    wait_tick(0, t);
    checks++; if (t - c0 !== 4) begin errors++; $display("FAIL reset_first_step got %0d want 4", t - c0); end
    @(negedge clk);
    checks++; if (led0 !== 3'b001) begin errors++; $display("FAIL reset_first_led got %b want 001", led0); end
    // Assert reset asynchronously while a step pulse is active.
    wait_tick(0, t);
    #1 rst[0] = 1'b1;
    #1;
    checks++; if (led0 !== 3'b000) begin errors++; $display("FAIL midrst_led got %b want 000", led0); end
    checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b want 0", tick[0]); end
    @(negedge clk);
    rst[0] = 1'b0; c0 = cyc;
    wait_tick(0, t);
    checks++; if (t - c0 !== 4) begin errors++; $display("FAIL post_rst_step got %0d want 4", t - c0); end
    @(negedge clk);
    checks++; if (led0 !== 3'b001) begin errors++; $display("FAIL post_rst_led got %b want 001", led0); end
  endtask

  task automatic test_chase;
    logic [2:0] exp_c [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001};
    int prev, t;
    do_reset(0);
    en[0] = 1'b1; mode[0] = MODE_CHASE; prev = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_tick(0, t);
      checks++; if (t - prev !== 4) begin errors++; $display("FAIL chase_spacing[%0d] got %0d want 4", k, t - prev); end
      prev = t;
      @(negedge clk);
      checks++; if (led0 !== exp_c[k]) begin errors++; $display("FAIL chase_led[%0d] got %b want %b", k, led0, exp_c[k]); end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] exp_b [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    int t;
    do_reset(1);
    en[1] = 1'b1; mode[1] = MODE_BOUNCE;
    for (int k = 0; k < 8; k++) begin
      wait_tick(1, t);
      @(negedge clk);
      checks++; if (t < 0 || led1 !== exp_b[k]) begin errors++; $display("FAIL bounce_led[%0d] got %b want %b t=%0d", k, led1, exp_b[k], t); end
    end
  endtask

  task automatic test_blink_off;
    logic [2:0] exp_k [3] = '{3'b111, 3'b000, 3'b111};
    int t;
    do_reset(0);
    en[0] = 1'b1; mode[0] = MODE_BLINK;
    for (int k = 0; k < 3; k++) begin
      wait_tick(0, t);
      @(negedge clk);
      checks++; if (t < 0 || led0 !== exp_k[k]) begin errors++; $display("FAIL blink_led[%0d] got %b want %b", k, led0, exp_k[k]); end
    end
    mode[0] = MODE_OFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (led0 !== 3'b111) begin errors++; $display("FAIL off_hold[%0d] got %b want 111", k, led0); end
    end
    for (int k = 0; k < 2; k++) begin
      wait_tick(0, t);
      @(negedge clk);
      checks++; if (t < 0 || led0 !== 3'b000) begin errors++; $display("FAIL off_led[%0d] got %b want 000", k, led0); end
    end
  endtask

  task automatic test_enable;
    int t, c0, bad;
    do_reset(0);
    en[0] = 1'b1; mode[0] = MODE_CHASE;
    repeat (2) begin
      wait_tick(0, t);
      @(negedge clk);
    end
    checks++; if (led0 !== 3'b010) begin errors++; $display("FAIL en_pre got %b want 010", led0); end
    en[0] = 1'b0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick[0] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_gate_ticks got %0d want 0", bad); end
    checks++; if (led0 !== 3'b010) begin errors++; $display("FAIL en_gate_led got %b want 010", led0); end
    en[0] = 1'b1; c0 = cyc;
    wait_tick(0, t);
    checks++; if (t - c0 !== 4) begin errors++; $display("FAIL en_resume got %0d want 4", t - c0); end
    @(negedge clk);
    checks++; if (led0 !== 3'b100) begin errors++; $display("FAIL en_resume_led got %b want 100", led0); end
  endtask

  task automatic test_edges;
    logic [2:0] exp_t [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001};
    logic       exp_n [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int t;
    // TICK_DIV=1: a step on every enabled cycle.
    do_reset(2);
    en[2] = 1'b1; mode[2] = MODE_CHASE;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (tick[2] !== 1'b1 || led2 !== exp_t[k]) begin
        errors++; $display("FAIL div1[%0d] tick=%b led=%b want tick=1 led=%b", k, tick[2], led2, exp_t[k]);
      end
    end
    // NUM_LEDS=1: chase 1,0,1 then bounce stays 1.
    do_reset(3);
    en[3] = 1'b1; mode[3] = MODE_CHASE;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) mode[3] = MODE_BOUNCE;
      wait_tick(3, t);
      @(negedge clk);
      checks++; if (t < 0 || led3 !== exp_n[k]) begin errors++; $display("FAIL n1[%0d] got %b want %b", k, led3, exp_n[k]); end
    end
    // Chase to pos=2, then switch to bounce.
    do_reset(0);
    en[0] = 1'b1; mode[0] = MODE_CHASE;
    repeat (3) begin
      wait_tick(0, t);
      @(negedge clk);
    end
    checks++; if (led0 !== 3'b100) begin errors++; $display("FAIL switch_pre got %b want 100", led0); end
    mode[0] = MODE_BOUNCE;
    wait_tick(0, t);
    @(negedge clk);
    checks++; if (led0 !== 3'b001) begin errors++; $display("FAIL switch_first got %b want 001", led0); end
    wait_tick(0, t);
    @(negedge clk);
    checks++; if (led0 !== 3'b010) begin errors++; $display("FAIL switch_second got %b want 010", led0); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i]  = 1'b1;
      en[i]   = 1'b0;
      mode[i] = MODE_OFF;
    end
    test_reset();
    test_chase();
    test_bounce();
    test_blink_off();
    test_enable();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
